// File: rtl/twos_acc_pkg.sv
// Shared types and helpers for the two's-complement block accumulator.
// The state enum and the constant and sign-extension helpers are used by
// twos_block_accumulator and twos_sat_add.
package twos_acc_pkg;

   typedef enum logic {
      ACCUM  = 1'b0,
      OUTPUT = 1'b1
   } state_t;

   // Largest positive value of a signed w-bit number, in the low w bits.
   // The helpers work on 32-bit values, so w must be 1..32.
   function automatic logic [31:0] acc_max(input int w);
      return (32'd1 << (w - 1)) - 32'd1;
   endfunction

   // Most negative value of a signed w-bit number: 1 followed by zeros.
   // The bits above w are ones; callers truncate to w bits.
   function automatic logic [31:0] acc_min(input int w);
      return ~acc_max(w);
   endfunction

   // Sign-extend the low w bits of v to 32 bits.
   function automatic logic [31:0] sext(input logic [31:0] v, input int w);
      logic [31:0] upper_mask;
      logic        sign_bit;
      upper_mask = 32'hFFFF_FFFF << w;
      sign_bit   = |(v & (32'd1 << (w - 1)));
      return sign_bit ? (v | upper_mask) : (v & ~upper_mask);
   endfunction

endpackage

// File: rtl/twos_sat_add.sv
// Combinational signed ACC_W-bit adder with an overflow flag.
// Optional macro SATURATE_EN clamps the result to the signed range on
// overflow. Without it the result wraps modulo 2^ACC_W.
import twos_acc_pkg::*;

module twos_sat_add #(
   parameter int ACC_W = 8
) (
   input  logic [ACC_W-1:0] a,
   input  logic [ACC_W-1:0] b,
   output logic [ACC_W-1:0] sum,
   output logic             ovf
);

   logic [ACC_W-1:0] raw_sum;

   assign raw_sum = a + b;

   // Overflow: the operands share a sign but the wrapped sum does not.
   assign ovf = (a[ACC_W-1] == b[ACC_W-1]) && (raw_sum[ACC_W-1] != a[ACC_W-1]);

`ifdef SATURATE_EN
   localparam logic [ACC_W-1:0] MAX_V = ACC_W'(acc_max(ACC_W));
   localparam logic [ACC_W-1:0] MIN_V = ACC_W'(acc_min(ACC_W));

   // On overflow the operand sign shows which rail was crossed.
   always_comb begin
      sum = raw_sum;
      if (ovf) begin
         sum = a[ACC_W-1] ? MIN_V : MAX_V;
      end
   end
`else
   assign sum = raw_sum;
`endif

endmodule

// File: rtl/twos_block_accumulator.sv
// Sums BLOCK_LEN signed WIDTH-bit samples into one signed ACC_W-bit result.
// Input and output use valid/ready handshakes, and each result carries a sticky
// overflow flag. Optional macro SATURATE_EN selects saturating accumulation
// instead of wrap-around. ACC_W is limited to 32 bits by the package helpers.
import twos_acc_pkg::*;

module twos_block_accumulator #(
   parameter int WIDTH     = 4,
   parameter int ACC_W     = 8,
   parameter int BLOCK_LEN = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic [WIDTH-1:0]               in_data,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ACC_W-1:0]               out_sum,
   output logic                           out_ovf,
   output logic [$clog2(BLOCK_LEN+1)-1:0] smp_cnt
);

   localparam int             CNT_W    = $clog2(BLOCK_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   state_t           state_reg;
   logic [ACC_W-1:0] acc_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic             ovf_reg;
   logic             in_ready_reg;
   logic             out_valid_reg;

   logic [ACC_W-1:0] in_ext;
   logic [ACC_W-1:0] add_sum;
   logic             add_ovf;
   logic             accept;

   assign in_ext = ACC_W'(sext(32'(in_data), WIDTH));

   twos_sat_add #(
      .ACC_W (ACC_W)
   ) u_add (
      .a   (acc_reg),
      .b   (in_ext),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // in_ready_reg is only high in ACCUM, so it also gates accepts by state.
   assign accept = in_valid && in_ready_reg;

   // Block FSM: accumulate BLOCK_LEN samples, then hold the result until it drains.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg     <= ACCUM;
         acc_reg       <= '0;
         cnt_reg       <= '0;
         ovf_reg       <= 1'b0;
         in_ready_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
      end else begin
         case (state_reg)
            ACCUM: begin
               in_ready_reg <= 1'b1;
               if (accept) begin
                  acc_reg <= add_sum;
                  ovf_reg <= ovf_reg | add_ovf;
                  cnt_reg <= cnt_reg + CNT_W'(1);
                  if (cnt_reg == LAST_CNT) begin
                     state_reg     <= OUTPUT;
                     in_ready_reg  <= 1'b0;
                     out_valid_reg <= 1'b1;
                  end
               end
            end
            OUTPUT: begin
               if (out_ready) begin
                  state_reg     <= ACCUM;
                  acc_reg       <= '0;
                  cnt_reg       <= '0;
                  ovf_reg       <= 1'b0;
                  out_valid_reg <= 1'b0;
                  in_ready_reg  <= 1'b1;
               end
            end
            default: begin
               state_reg <= ACCUM;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_reg;
   assign out_valid = out_valid_reg;
   assign out_sum   = acc_reg;
   assign out_ovf   = ovf_reg;
   assign smp_cnt   = cnt_reg;

endmodule

// File: tb/tb_twos_block_accumulator.sv
// Testbench for twos_block_accumulator. It runs two instances in lockstep:
// one with ACC_W=8 and one with ACC_W=5, the second so that blocks can
// overflow. Expected results come from an integer-arithmetic model of the
// block sum, with wrap or clamp chosen by SATURATE_EN.
`timescale 1ns/1ps

module tb_twos_block_accumulator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid;
   logic [3:0] in_data;
   logic       out_ready;

   logic       in_ready,  out_valid,  out_ovf;
   logic [7:0] out_sum;
   logic [2:0] smp_cnt;
   logic       in_ready5, out_valid5, out_ovf5;
   logic [4:0] out_sum5;
   logic [2:0] smp_cnt5;

   int cmp_cnt = 0;
   int mis_cnt = 0;

   // Model state: exact block sums per accumulator width, sticky flags, sample count.
   int m8, m5, mcnt;
   bit o8, o5;

   always #5 clk = ~clk;

   twos_block_accumulator #(.WIDTH(4), .ACC_W(8), .BLOCK_LEN(4)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_ovf(out_ovf), .smp_cnt(smp_cnt)
   );

   twos_block_accumulator #(.WIDTH(4), .ACC_W(5), .BLOCK_LEN(4)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready5),
      .in_data(in_data), .out_valid(out_valid5), .out_ready(out_ready),
      .out_sum(out_sum5), .out_ovf(out_ovf5), .smp_cnt(smp_cnt5)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      cmp_cnt++;
      assert (obs === exp) else begin
         mis_cnt++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One model addition in w bits. Returns the new value and whether the
   // exact sum left the signed range.
   task automatic step(input int acc, input int x, input int w, output int res, output bit ov);
      int hi, lo, s;
      hi = (1 << (w - 1)) - 1;
      lo = -(1 << (w - 1));
      s  = acc + x;
      ov = 1'b0;
      if (s > hi || s < lo) begin
         ov = 1'b1;
`ifdef SATURATE_EN
         s = (s > hi) ? hi : lo;
`else
         s = (s > hi) ? s - (1 << w) : s + (1 << w);
`endif
      end
      res = s;
   endtask

   task automatic model_clear();
      m8 = 0; m5 = 0; mcnt = 0; o8 = 1'b0; o5 = 1'b0;
   endtask

   task automatic model_accept(input logic [3:0] d);
      int x, r;
      bit ov;
      x = int'($signed(d));
      step(m8, x, 8, r, ov); m8 = r; o8 = o8 | ov;
      step(m5, x, 5, r, ov); m5 = r; o5 = o5 | ov;
      mcnt++;
   endtask

   // Present one sample after gap idle cycles and wait for it to be taken.
   // Starts and ends just after a falling edge.
   task automatic send(input logic [3:0] d, input int gap);
      int t;
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      t = 0;
      while (in_ready !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("accept_wait", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      model_accept(d);
      $display("sample in=%0d cnt=%0d out_valid=%0b", int'($signed(d)), smp_cnt, out_valid);
      check("smp_cnt", 32'(smp_cnt), 32'(mcnt));
      check("valid_after_accept", 32'(out_valid), 32'(mcnt == 4));
   endtask

   // Wait for a result, check it, hold it for hold cycles under in_valid
   // pulses, then drain it.
   task automatic recv(input int hold);
      int t;
      logic [7:0] held;
      t = 0;
      while (out_valid !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      $display("result sum8=%0d ovf8=%0b sum5=%0d ovf5=%0b exp8=%0d exp5=%0d",
               $signed(out_sum), out_ovf, $signed(out_sum5), out_ovf5, m8, m5);
      check("out_valid", 32'(out_valid), 32'd1);
      check("in_ready_out", 32'(in_ready), 32'd0);
      check("out_sum8", 32'(out_sum), 32'(m8) & 32'hFF);
      check("out_ovf8", 32'(out_ovf), 32'(o8));
      check("out_sum5", 32'(out_sum5), 32'(m5) & 32'h1F);
      check("out_ovf5", 32'(out_ovf5), 32'(o5));
      check("out_valid5", 32'(out_valid5), 32'd1);
      held = out_sum;
      out_ready = 1'b0;
      for (int i = 0; i < hold; i++) begin
         in_valid = 1'b1;
         in_data  = 4'($urandom_range(0, 15));
         @(negedge clk);
         in_valid = 1'b0;
         check("hold_sum", 32'(out_sum), 32'(held));
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("drain_valid", 32'(out_valid), 32'd0);
      check("drain_cnt", 32'(smp_cnt), 32'd0);
      check("drain_sum", 32'(out_sum), 32'd0);
      check("drain_in_ready", 32'(in_ready), 32'd1);
      check("drain_cnt5", 32'(smp_cnt5), 32'd0);
      check("drain_in_ready5", 32'(in_ready5), 32'd1);
      model_clear();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum", 32'(out_sum), 32'd0);
      check("rst_out_ovf", 32'(out_ovf), 32'd0);
      check("rst_smp_cnt", 32'(smp_cnt), 32'd0);
      check("rst_out_valid5", 32'(out_valid5), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);
      model_clear();
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = 4'h0;
      out_ready = 1'b0;
      model_clear();
      @(negedge clk);
      do_reset();

      // 1: back-to-back 1,2,3,4 with out_ready held high -> 10.
      out_ready = 1'b1;
      send(4'd1, 0); send(4'd2, 0); send(4'd3, 0); send(4'd4, 0);
      recv(0);

      // 2: four -8 samples -> -32, checks sign extension.
      send(4'h8, 0); send(4'h8, 0); send(4'h8, 0); send(4'h8, 0);
      recv(0);

      // 3: four 7 samples -> the 5-bit instance overflows.
      send(4'd7, 0); send(4'd7, 0); send(4'd7, 0); send(4'd7, 0);
      recv(0);

      // 4: backpressure for 5 cycles, then the next block must start from 0.
      send(4'd5, 0); send(4'd6, 0); send(4'hF, 0); send(4'd2, 0);
      recv(5);
      send(4'd1, 0); send(4'd1, 0); send(4'd1, 0); send(4'd1, 0);
      recv(0);

      // 5: gapped in_valid with 2,-3,5,-1 -> 3.
      send(4'd2, 1); send(4'hD, 1); send(4'd5, 1); send(4'hF, 1);
      recv(0);

      // 6: reset after two samples, then four 1s -> a single result of 4.
      send(4'd7, 0); send(4'd7, 0);
      do_reset();
      check("no_stale_valid", 32'(out_valid), 32'd0);
      send(4'd1, 0); send(4'd1, 0); send(4'd1, 0); send(4'd1, 0);
      recv(0);

      // Reset while a result is pending discards it.
      send(4'd3, 0); send(4'd3, 0); send(4'd3, 0); send(4'd3, 0);
      do_reset();
      check("pending_discarded", 32'(out_valid), 32'd0);

      // Random blocks with random gaps and backpressure.
      for (int b = 0; b < 25; b++) begin
         for (int s = 0; s < 4; s++) begin
            send(4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
         end
         recv(int'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
      $finish;
   end

endmodule
